// File: rtl/silly_pkg.sv
// Shared constants for the silly_window statistics datapath.
// Mode encodings select which statistic drives uo_out.
package silly_pkg;

  localparam logic [1:0] MODE_DELAY = 2'd0;
  localparam logic [1:0] MODE_SUM   = 2'd1;
  localparam logic [1:0] MODE_MAX   = 2'd2;
  localparam logic [1:0] MODE_CHG   = 2'd3;

  // Windowed modes only report once the window has filled.
  function automatic logic windowed(input logic [1:0] m);
    return (m == MODE_DELAY) || (m == MODE_SUM);
  endfunction

endpackage

// File: rtl/silly_delay_line.sv
// DEPTH-deep sample shift register with shift-enable and sync clear.
// Exposes the oldest tap both before and after the current shift.
module silly_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap_pre,
  output logic [WIDTH-1:0] tap_post
);

  logic [WIDTH-1:0] tap [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) tap[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) tap[k] <= '0;
    end else if (shift) begin
      tap[0] <= din;
      for (int k = 1; k < DEPTH; k++) tap[k] <= tap[k-1];
    end
  end

  assign tap_pre  = tap[DEPTH-1];
  assign tap_post = shift ? tap[DEPTH-2] : tap[DEPTH-1];

endmodule

// File: rtl/silly_window.sv
// Sliding-window statistics: delay tap, moving sum, running max and
// change count, one selected by mode onto a registered output.
module silly_window
  import silly_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] uo_out,
  output logic             out_valid,
  output logic             window_full,
  output logic             sat
);

  localparam int SUMW  = WIDTH + $clog2(DEPTH);
  localparam int FILLW = $clog2(DEPTH) + 1;
  localparam logic [FILLW-1:0] FULL = FILLW'(DEPTH);

  logic             accept;
  logic             clear;
  logic [WIDTH-1:0] tap_pre;
  logic [WIDTH-1:0] tap_post;

  logic [FILLW-1:0] fill;
  logic [SUMW-1:0]  sum;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] last;

  logic [FILLW-1:0] fill_nxt;
  logic [SUMW-1:0]  sum_nxt;
  logic [WIDTH-1:0] max_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             full_nxt;
  logic             sum_hi;
  logic [WIDTH-1:0] sel;
  logic             ov_nxt;

  assign accept = ena & in_valid & ~clr;
  assign clear  = ena & clr;

  silly_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_dl (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift    (accept),
    .clr      (clear),
    .din      (ui_in),
    .tap_pre  (tap_pre),
    .tap_post (tap_post)
  );

  // Oldest sample is already in sum, so the result never wraps.
  assign sum_nxt  = sum - SUMW'(tap_pre) + SUMW'(ui_in);
  assign sum_hi   = |sum_nxt[SUMW-1:WIDTH];
  assign max_nxt  = (ui_in > max) ? ui_in : max;
  assign cnt_nxt  = (ui_in != last) ? cnt + 1'b1 : cnt;
  assign fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
  assign full_nxt = (fill_nxt == FULL);
  assign ov_nxt   = windowed(mode) ? full_nxt : 1'b1;

  always_comb begin
    sel = '0;
    unique case (1'b1)
      mode == MODE_DELAY: sel = tap_post;
      mode == MODE_SUM:
        sel = sum_hi ? {WIDTH{1'b1}} : sum_nxt[WIDTH-1:0];
      mode == MODE_MAX:   sel = max_nxt;
      mode == MODE_CHG:   sel = cnt_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill      <= '0;
      sum       <= '0;
      max       <= '0;
      cnt       <= '0;
      last      <= '0;
      uo_out    <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else if (clear) begin
      fill      <= '0;
      sum       <= '0;
      max       <= '0;
      cnt       <= '0;
      last      <= '0;
      uo_out    <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      out_valid <= accept & ov_nxt;
      if (accept) begin
        fill   <= fill_nxt;
        sum    <= sum_nxt;
        max    <= max_nxt;
        cnt    <= cnt_nxt;
        last   <= ui_in;
        uo_out <= sel;
        sat    <= (mode == MODE_SUM) & sum_hi;
      end
    end
  end

  assign window_full = (fill == FULL);

endmodule

// File: tb/tb_silly_window.sv
// Bench for silly_window: directed vector table, randomized run
// against a sample-history model, and a mid-stream async reset.
module tb_silly_window;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] ui_in = '0;
  logic [1:0] mode = '0;
  logic       clr = 1'b0;
  logic [7:0] uo_out;
  logic       out_valid;
  logic       window_full;
  logic       sat;

  int n_chk = 0;
  int n_fail = 0;

  silly_window #(.WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_valid    (in_valid),
    .ui_in       (ui_in),
    .mode        (mode),
    .clr         (clr),
    .uo_out      (uo_out),
    .out_valid   (out_valid),
    .window_full (window_full),
    .sat         (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic       v;
    logic       c;
    logic [1:0] m;
    logic [7:0] u;
    logic [7:0] uo;
    logic       ov;
    logic       full;
    logic       sat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic e, input logic v, input logic c,
    input logic [1:0] m, input logic [7:0] u,
    input logic [7:0] uo, input logic ov,
    input logic full, input logic s);
    vec_t r;
    r.e = e; r.v = v; r.c = c; r.m = m; r.u = u;
    r.uo = uo; r.ov = ov; r.full = full; r.sat = s;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] uo,
                         input logic ov, input logic full,
                         input logic s);
    chk({tag, ".uo_out"}, int'(uo_out), int'(uo));
    chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
    chk({tag, ".window_full"}, int'(window_full), int'(full));
    chk({tag, ".sat"}, int'(sat), int'(s));
  endtask

  task automatic drive(input logic e, input logic v, input logic c,
                       input logic [1:0] m, input logic [7:0] u);
    @(negedge clk);
    ena = e; in_valid = v; clr = c; mode = m; ui_in = u;
    @(posedge clk);
    #1;
  endtask

  // Reference model: full history of samples accepted since clear.
  int         q[$];
  logic [7:0] m_uo;
  logic       m_ov;
  logic       m_sat;

  function automatic void mdl_clear();
    q.delete();
    m_uo = '0; m_ov = 1'b0; m_sat = 1'b0;
  endfunction

  function automatic void mdl_step(input logic e, input logic v,
                                   input logic c, input logic [1:0] m,
                                   input logic [7:0] u);
    int n, s, mx, ch, prev, tp;
    if (!e) begin
      m_ov = 1'b0;
    end else if (c) begin
      mdl_clear();
    end else if (!v) begin
      m_ov = 1'b0;
    end else begin
      q.push_back(int'(u));
      n = q.size();
      s = 0;
      for (int i = (n > 4 ? n - 4 : 0); i < n; i++) s += q[i];
      mx = 0; ch = 0;
      for (int i = 0; i < n; i++) begin
        prev = (i == 0) ? 0 : q[i-1];
        if (q[i] != prev) ch++;
        if (q[i] > mx) mx = q[i];
      end
      tp = (n >= 4) ? q[n-4] : 0;
      case (m)
        2'd0: m_uo = 8'(tp);
        2'd1: m_uo = (s > 255) ? 8'hFF : 8'(s);
        2'd2: m_uo = 8'(mx);
        default: m_uo = 8'(ch % 256);
      endcase
      m_ov  = (m < 2) ? (n >= 4) : 1'b1;
      m_sat = (m == 2'd1) && (s > 255);
    end
  endfunction

  initial begin
    vec_t t;
    logic e, v, c;
    logic [1:0] m;
    logic [7:0] u;

    // Mode 1 fill and slide
    vt.push_back(mk(1,1,0,1,8'h01, 8'h01,0,0,0));
    vt.push_back(mk(1,1,0,1,8'h02, 8'h03,0,0,0));
    vt.push_back(mk(1,1,0,1,8'h03, 8'h06,0,0,0));
    vt.push_back(mk(1,1,0,1,8'h04, 8'h0A,1,1,0));
    vt.push_back(mk(1,1,0,1,8'h05, 8'h0E,1,1,0));
    vt.push_back(mk(1,0,0,1,8'h00, 8'h0E,0,1,0));
    vt.push_back(mk(1,0,1,1,8'h00, 8'h00,0,0,0));
    // Mode 1 saturation, sat held across ena=0
    vt.push_back(mk(1,1,0,1,8'hFF, 8'hFF,0,0,0));
    vt.push_back(mk(1,1,0,1,8'hFF, 8'hFF,0,0,1));
    vt.push_back(mk(1,1,0,1,8'hFF, 8'hFF,0,0,1));
    vt.push_back(mk(1,1,0,1,8'hFF, 8'hFF,1,1,1));
    vt.push_back(mk(0,1,0,1,8'h00, 8'hFF,0,1,1));
    vt.push_back(mk(1,1,0,1,8'h00, 8'hFF,1,1,1));
    vt.push_back(mk(1,1,0,1,8'h00, 8'hFF,1,1,1));
    vt.push_back(mk(1,1,0,1,8'h00, 8'hFF,1,1,0));
    vt.push_back(mk(1,1,0,1,8'h00, 8'h00,1,1,0));
    vt.push_back(mk(1,0,1,0,8'h00, 8'h00,0,0,0));
    // Mode 0 delay tap
    vt.push_back(mk(1,1,0,0,8'h01, 8'h00,0,0,0));
    vt.push_back(mk(1,1,0,0,8'h02, 8'h00,0,0,0));
    vt.push_back(mk(1,1,0,0,8'h03, 8'h00,0,0,0));
    vt.push_back(mk(1,1,0,0,8'h04, 8'h01,1,1,0));
    vt.push_back(mk(1,1,0,0,8'h05, 8'h02,1,1,0));
    vt.push_back(mk(1,1,0,0,8'h06, 8'h03,1,1,0));
    vt.push_back(mk(1,0,1,2,8'h00, 8'h00,0,0,0));
    // Mode 2 max, clr beats in_valid
    vt.push_back(mk(1,1,0,2,8'h10, 8'h10,1,0,0));
    vt.push_back(mk(1,1,0,2,8'h80, 8'h80,1,0,0));
    vt.push_back(mk(1,1,0,2,8'h20, 8'h80,1,0,0));
    vt.push_back(mk(1,1,1,2,8'hFF, 8'h00,0,0,0));
    vt.push_back(mk(1,1,0,2,8'h05, 8'h05,1,0,0));
    vt.push_back(mk(1,0,1,3,8'h00, 8'h00,0,0,0));
    // Mode 3 change count, ena gating
    vt.push_back(mk(1,1,0,3,8'h01, 8'h01,1,0,0));
    vt.push_back(mk(1,1,0,3,8'h01, 8'h01,1,0,0));
    vt.push_back(mk(1,1,0,3,8'h02, 8'h02,1,0,0));
    vt.push_back(mk(1,1,0,3,8'h02, 8'h02,1,1,0));
    vt.push_back(mk(1,1,0,3,8'h03, 8'h03,1,1,0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,0,3,8'h77, 8'h03,0,1,0));
    vt.push_back(mk(0,1,1,3,8'h00, 8'h03,0,1,0));
    vt.push_back(mk(1,1,0,2,8'h03, 8'h03,1,1,0));

    repeat (2) @(posedge clk);
    #3;
    chk_all("rst", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_rel", 8'h00, 0, 0, 0);

    foreach (vt[i]) begin
      t = vt[i];
      drive(t.e, t.v, t.c, t.m, t.u);
      chk_all($sformatf("vec%0d", i), t.uo, t.ov, t.full, t.sat);
    end

    drive(1, 0, 1, 0, 8'h00);
    mdl_clear();
    chk_all("pre_rand", 8'h00, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 49) == 0);
      m = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: u = 8'hFF;
        1: u = 8'($urandom_range(0, 3));
        default: u = 8'($urandom);
      endcase
      drive(e, v, c, m, u);
      mdl_step(e, v, c, m, u);
      chk_all($sformatf("rnd%0d", i), m_uo, m_ov,
              (q.size() >= 4), m_sat);
    end

    // Mid-stream asynchronous reset
    drive(1, 1, 0, 2, 8'hFF);
    drive(1, 1, 0, 2, 8'hA5);
    chk("pre_rst.uo_out", int'(uo_out), 32'hFF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rst_idle", 8'h00, 0, 0, 0);
    drive(1, 1, 0, 2, 8'h42);
    chk_all("rst_first", 8'h42, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
